// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch, decode, execute, data memory and write-back,
// driving every datapath enable/select from the current state and the latched opcode.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    input  logic        IMEM_ready,
    input  logic        DMEM_ready,
    output logic        IR_LdEn,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic        RF_WrEn,
    output logic        RF_WrData_sel,
    output logic        RF_B_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        MEM_RdEn,
    output logic        MEM_WrEn,
    output logic        Illegal,
    output logic [2:0]  State
);

    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DEC   = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b010000;
    localparam logic [5:0] OP_BNE  = 6'b010001;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [5:0]       r_op;
    logic [3:0]       r_func;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [5:0] w_op;
    logic       w_is_r, w_is_alui, w_is_andi, w_is_ori, w_is_lw, w_is_sw;
    logic       w_is_b, w_is_beq, w_is_bne, w_is_branch, w_is_legal;
    logic       w_timeout;
    logic       w_unused;

    // Decode reads the live IR word during S_DEC and the latched opcode afterwards
    assign w_op        = (r_state == S_DEC) ? Instr[31:26] : r_op;
    assign w_is_r      = (w_op == OP_R);
    assign w_is_andi   = (w_op == OP_ANDI);
    assign w_is_ori    = (w_op == OP_ORI);
    assign w_is_alui   = (w_op == OP_ADDI) || w_is_andi || w_is_ori || (w_op == OP_LI);
    assign w_is_lw     = (w_op == OP_LW);
    assign w_is_sw     = (w_op == OP_SW);
    assign w_is_b      = (w_op == OP_B);
    assign w_is_beq    = (w_op == OP_BEQ);
    assign w_is_bne    = (w_op == OP_BNE);
    assign w_is_branch = w_is_b || w_is_beq || w_is_bne;
    assign w_is_legal  = w_is_r || w_is_alui || w_is_lw || w_is_sw || w_is_branch;
    assign w_timeout   = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign w_unused    = ^Instr[25:4];

    assign State = r_state;

    // State, latched opcode/function and data-memory wait counter
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_op       <= 6'd0;
            r_func     <= 4'd0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_DEC) begin
                r_op   <= Instr[31:26];
                r_func <= Instr[3:0];
            end
            if (r_state == S_EXE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_MEM) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and per-phase datapath controls
    always_comb begin
        w_state_nxt   = r_state;
        IR_LdEn       = 1'b0;
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = 4'b0000;
        MEM_RdEn      = 1'b0;
        MEM_WrEn      = 1'b0;
        Illegal       = 1'b0;

        case (r_state)
            S_FETCH: begin
                IR_LdEn = IMEM_ready;
                if (IMEM_ready) begin
                    w_state_nxt = S_DEC;
                end
            end
            S_DEC: begin
                RF_B_sel = !w_is_r;
                if (!w_is_legal) begin
                    Illegal     = 1'b1;
                    PC_LdEn     = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_EXE;
                end
            end
            S_EXE: begin
                RF_B_sel    = !w_is_r;
                ALU_Bin_sel = !(w_is_r || w_is_beq || w_is_bne);
                if (w_is_r) begin
                    ALU_func = r_func;
                end else if (w_is_andi) begin
                    ALU_func = 4'b0010;
                end else if (w_is_ori) begin
                    ALU_func = 4'b0011;
                end else if (w_is_beq || w_is_bne) begin
                    ALU_func = 4'b0001;
                end
                if (w_is_branch) begin
                    PC_LdEn     = 1'b1;
                    PC_sel      = w_is_b || (w_is_beq && ALU_zero) || (w_is_bne && !ALU_zero);
                    w_state_nxt = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                RF_B_sel = !w_is_r;
                // A late ready on the final allowed cycle still completes the access
                if (DMEM_ready) begin
                    MEM_RdEn = w_is_lw;
                    MEM_WrEn = w_is_sw;
                    if (w_is_lw) begin
                        w_state_nxt = S_WB;
                    end else begin
                        PC_LdEn     = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end else if (w_timeout) begin
                    Illegal     = 1'b1;
                    PC_LdEn     = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    MEM_RdEn = w_is_lw;
                    MEM_WrEn = w_is_sw;
                end
            end
            S_WB: begin
                RF_B_sel      = !w_is_r;
                RF_WrEn       = 1'b1;
                RF_WrData_sel = w_is_lw;
                PC_LdEn       = 1'b1;
                w_state_nxt   = S_FETCH;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // Reset forces every control quiet immediately, before any clock edge
        if (!reset) begin
            IR_LdEn       = 1'b0;
            PC_LdEn       = 1'b0;
            PC_sel        = 1'b0;
            RF_WrEn       = 1'b0;
            RF_WrData_sel = 1'b0;
            RF_B_sel      = 1'b0;
            ALU_Bin_sel   = 1'b0;
            ALU_func      = 4'b0000;
            MEM_RdEn      = 1'b0;
            MEM_WrEn      = 1'b0;
            Illegal       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle stimulus pushes the expected
// control bundle, a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       ir;
        logic       pcld;
        logic       pcsel;
        logic       rfwr;
        logic       wdsel;
        logic       bsel;
        logic       binsel;
        logic [3:0] func;
        logic       rd;
        logic       wr;
        logic       ill;
    } obs_t;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_DEC   = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    localparam logic [31:0] I_ADD  = {6'b100000, 20'h0A5C3, 6'b000000};
    localparam logic [31:0] I_SUB  = {6'b100000, 20'h01234, 6'b000101};
    localparam logic [31:0] I_LW   = {6'b001111, 26'h2ABCDEF};
    localparam logic [31:0] I_SW   = {6'b011111, 26'h1234567};
    localparam logic [31:0] I_BEQ  = {6'b010000, 26'h0000010};
    localparam logic [31:0] I_BNE  = {6'b010001, 26'h0000010};
    localparam logic [31:0] I_B    = {6'b111111, 26'h3FFFFFF};
    localparam logic [31:0] I_ANDI = {6'b110010, 26'h0000000};
    localparam logic [31:0] I_ORI  = {6'b110011, 26'h0000F0F};
    localparam logic [31:0] I_BAD  = {6'b000000, 26'h0000020};

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr = 32'd0;
    logic        ALU_zero = 1'b0;
    logic        IMEM_ready = 1'b1;
    logic        DMEM_ready = 1'b0;
    logic        IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_RdEn, MEM_WrEn, Illegal;
    logic [2:0]  State;

    obs_t        obs;
    obs_t        exp_q[$];
    string       tag_q[$];
    logic [31:0] next_instr = 32'd0;
    int          n_tests = 0;
    int          n_fail = 0;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .Clk(Clk), .reset(reset), .Instr(Instr), .ALU_zero(ALU_zero),
        .IMEM_ready(IMEM_ready), .DMEM_ready(DMEM_ready),
        .IR_LdEn(IR_LdEn), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .MEM_RdEn(MEM_RdEn), .MEM_WrEn(MEM_WrEn),
        .Illegal(Illegal), .State(State)
    );

    always #5 Clk = ~Clk;

    assign obs = {State, IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel,
                  ALU_Bin_sel, ALU_func, MEM_RdEn, MEM_WrEn, Illegal};

    // Field order: state, ir, pcld, pcsel, rfwr, wdsel, bsel, binsel, func, rd, wr, ill
    function automatic obs_t mk(input logic [2:0] st, input logic ir, pcld, pcsel, rfwr,
                                wdsel, bsel, binsel, input logic [3:0] func,
                                input logic rd, wr, ill);
        mk = {st, ir, pcld, pcsel, rfwr, wdsel, bsel, binsel, func, rd, wr, ill};
    endfunction

    // One cycle: drive inputs just after the edge and queue the bundle expected for it
    task automatic cyc(input logic rst, imr, dmr, zero, input obs_t e, input string tag);
        @(posedge Clk);
        #1;
        reset      = rst;
        Instr      = next_instr;
        IMEM_ready = imr;
        DMEM_ready = dmr;
        ALU_zero   = zero;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Fetch (DMEM_ready asserted to show it is ignored) then decode (IMEM_ready ignored)
    task automatic front(input logic [31:0] ins, input logic bsel, input string tag);
        next_instr = ins;
        cyc(1, 1, 1, 0, mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), {tag, "_fetch"});
        cyc(1, 1, 0, 0, mk(S_DEC,   0, 0, 0, 0, 0, bsel, 0, 4'h0, 0, 0, 0), {tag, "_dec"});
    endtask

    always @(negedge Clk) begin
        obs_t  e;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", t, obs, e);
            end
        end
    end

    initial begin
        // Reset held with IMEM_ready high: everything must stay quiet
        cyc(0, 1, 0, 0, '0, "reset_hold");
        cyc(1, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "fetch_stall");

        front(I_ADD, 0, "add");
        cyc(1, 1, 1, 0, mk(S_EXE, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "add_exe");
        cyc(1, 1, 1, 0, mk(S_WB,  0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0), "add_wb");

        front(I_SUB, 0, "rfunc");
        cyc(1, 0, 0, 1, mk(S_EXE, 0, 0, 0, 0, 0, 0, 0, 4'h5, 0, 0, 0), "rfunc_exe");
        cyc(1, 0, 0, 0, mk(S_WB,  0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0), "rfunc_wb");

        front(I_LW, 1, "lw");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0), "lw_exe");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, mk(S_MEM, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0), "lw_mem_wait");
        cyc(1, 0, 1, 0, mk(S_MEM, 0, 0, 0, 0, 0, 1, 0, 4'h0, 1, 0, 0), "lw_mem_ready");
        cyc(1, 0, 0, 0, mk(S_WB,  0, 1, 0, 1, 1, 1, 0, 4'h0, 0, 0, 0), "lw_wb");

        front(I_BEQ, 1, "beq");
        cyc(1, 0, 0, 1, mk(S_EXE, 0, 1, 1, 0, 0, 1, 0, 4'h1, 0, 0, 0), "beq_taken");
        front(I_BNE, 1, "bne");
        cyc(1, 0, 0, 1, mk(S_EXE, 0, 1, 0, 0, 0, 1, 0, 4'h1, 0, 0, 0), "bne_not_taken");
        front(I_B, 1, "b");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 1, 1, 0, 0, 1, 1, 4'h0, 0, 0, 0), "b_exe");

        front(I_ANDI, 1, "andi");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 1, 1, 4'h2, 0, 0, 0), "andi_exe");
        cyc(1, 0, 0, 0, mk(S_WB,  0, 1, 0, 1, 0, 1, 0, 4'h0, 0, 0, 0), "andi_wb");
        front(I_ORI, 1, "ori");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 1, 1, 4'h3, 0, 0, 0), "ori_exe");
        cyc(1, 0, 0, 0, mk(S_WB,  0, 1, 0, 1, 0, 1, 0, 4'h0, 0, 0, 0), "ori_wb");

        front(I_SW, 1, "sw");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0), "sw_exe");
        cyc(1, 0, 1, 0, mk(S_MEM, 0, 1, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0), "sw_mem_ready");

        // Store timing out after 15 cycles in S_MEM
        front(I_SW, 1, "swto");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0), "swto_exe");
        for (int i = 0; i < 14; i++)
            cyc(1, 0, 0, 0, mk(S_MEM, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0), "swto_wait");
        cyc(1, 0, 0, 0, mk(S_MEM,   0, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1), "swto_timeout");
        cyc(1, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "swto_after");

        // Ready on the very last allowed cycle wins over the timeout
        front(I_SW, 1, "swlate");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0), "swlate_exe");
        for (int i = 0; i < 14; i++)
            cyc(1, 0, 0, 0, mk(S_MEM, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0), "swlate_wait");
        cyc(1, 0, 1, 0, mk(S_MEM,   0, 1, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0), "swlate_ready");
        cyc(1, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "swlate_after");

        next_instr = I_BAD;
        cyc(1, 1, 0, 0, mk(S_FETCH, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "bad_fetch");
        cyc(1, 0, 0, 0, mk(S_DEC,   0, 1, 0, 0, 0, 1, 0, 4'h0, 0, 0, 1), "bad_dec");
        cyc(1, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "bad_after");

        // Reset dropped mid-store: outputs clear without waiting for an edge
        front(I_SW, 1, "swrst");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0), "swrst_exe");
        cyc(1, 0, 0, 0, mk(S_MEM, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 1, 0), "swrst_mem");
        cyc(0, 1, 1, 0, '0, "async_reset");
        cyc(1, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "reset_release");
        front(I_ADD, 0, "restart");
        cyc(1, 0, 0, 0, mk(S_EXE, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0), "restart_exe");
        cyc(1, 0, 0, 0, mk(S_WB,  0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0), "restart_wb");

        repeat (3) @(posedge Clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
